// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC lane/frame constants, lane index type and lane slice offset helper
package adc_pkg;

  localparam int SAMPLE_W         = 18;
  localparam int SAMPLES_PER_LANE = 12;
  localparam int LANE_W           = SAMPLE_W * SAMPLES_PER_LANE;
  localparam int NUM_LANES        = 4;
  localparam int FRAME_W          = LANE_W * NUM_LANES;
  localparam int LANE_IDX_W       = $clog2(NUM_LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

  // Bit offset of a lane within a frame; lane 0 sits at the LSBs.
  function automatic int lane_lo(input lane_idx_t idx);
    return int'(idx) * LANE_W;
  endfunction

endpackage

// File: rtl/adc_pack_outreg.sv
// rtl/adc_pack_outreg.sv - frame output register with valid/ready hold and handoff counter
// Optional ADC_PACK_LAST_EN adds registered last/keep sidebands.
module adc_pack_outreg
  import adc_pkg::*;
(
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_load,
  input  logic [FRAME_W-1:0]   i_data,
`ifdef ADC_PACK_LAST_EN
  input  logic                 i_last,
  input  logic [NUM_LANES-1:0] i_keep,
  output logic                 o_last,
  output logic [NUM_LANES-1:0] o_keep,
`endif
  input  logic                 i_ready,
  output logic [FRAME_W-1:0]   o_data,
  output logic                 o_valid,
  output logic [31:0]          o_frame_cnt
);

  logic [FRAME_W-1:0] r_data;
  logic               r_valid;
  logic [31:0]        r_frame_cnt;
`ifdef ADC_PACK_LAST_EN
  logic               r_last;
  logic [NUM_LANES-1:0] r_keep;
`endif

  // A load always wins over a drain so a same-cycle handoff keeps o_valid high.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && i_ready) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

`ifdef ADC_PACK_LAST_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last <= 1'b0;
      r_keep <= '0;
    end else if (i_load) begin
      r_last <= i_last;
      r_keep <= i_keep;
    end
  end

  assign o_last = r_last;
  assign o_keep = r_keep;
`endif

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/adc_data_packer.sv
// rtl/adc_data_packer.sv - rebuilds full ADC frames from successive lane beats
// Optional ADC_PACK_LAST_EN adds s_last/m_last/m_keep and early (short) frame emit.
module adc_data_packer
  import adc_pkg::*;
(
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [LANE_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
`ifdef ADC_PACK_LAST_EN
  input  logic                 s_last,
  output logic                 m_last,
  output logic [NUM_LANES-1:0] m_keep,
`endif
  output logic [FRAME_W-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          frame_cnt
);

  lane_idx_t                 r_lane_cnt;
  logic [FRAME_W-LANE_W-1:0] r_acc;

  logic                      w_emit;
  logic                      w_accept;
  logic                      w_load;
  logic [FRAME_W-1:0]        w_frame;

`ifdef ADC_PACK_LAST_EN
  logic [NUM_LANES-1:0]      w_keep;

  assign w_emit = (r_lane_cnt == LAST_LANE) || s_last;
`else
  assign w_emit = (r_lane_cnt == LAST_LANE);
`endif

  // Only an emitting beat can collide with an unconsumed frame; other beats go to the accumulator.
  assign s_ready  = aresetn && !(w_emit && m_valid && !m_ready);
  assign w_accept = s_valid && s_ready;
  assign w_load   = w_accept && w_emit;

  // Lanes below the current one come from the accumulator, the current lane from s_data, the rest stay zero.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUM_LANES - 1; k++) begin
      if (lane_idx_t'(k) < r_lane_cnt) begin
        w_frame[k*LANE_W +: LANE_W] = r_acc[k*LANE_W +: LANE_W];
      end
    end
    w_frame[lane_lo(r_lane_cnt) +: LANE_W] = s_data;
  end

`ifdef ADC_PACK_LAST_EN
  always_comb begin
    w_keep = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_keep[k] = (lane_idx_t'(k) <= r_lane_cnt);
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_lane_cnt <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      if (w_emit) begin
        r_lane_cnt <= '0;
      end else begin
        r_lane_cnt <= r_lane_cnt + lane_idx_t'(1);
        r_acc[lane_lo(r_lane_cnt) +: LANE_W] <= s_data;
      end
    end
  end

  adc_pack_outreg u_outreg (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_load      (w_load),
    .i_data      (w_frame),
`ifdef ADC_PACK_LAST_EN
    .i_last      (s_last),
    .i_keep      (w_keep),
    .o_last      (m_last),
    .o_keep      (m_keep),
`endif
    .i_ready     (m_ready),
    .o_data      (m_data),
    .o_valid     (m_valid),
    .o_frame_cnt (frame_cnt)
  );

endmodule

// File: tb/tb_adc_data_packer.sv
// tb/tb_adc_data_packer.sv - scoreboard bench for adc_data_packer (ADC_PACK_LAST_EN optional)
module tb_adc_data_packer;
  import adc_pkg::*;

`ifdef ADC_PACK_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  typedef struct {
    logic [FRAME_W-1:0]   data;
    logic [NUM_LANES-1:0] keep;
    logic                 last;
  } frame_t;

  logic                 aclk    = 1'b0;
  logic                 aresetn = 1'b0;
  logic [LANE_W-1:0]    s_data  = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [FRAME_W-1:0]   m_data;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [31:0]          frame_cnt;
`ifdef ADC_PACK_LAST_EN
  logic                 s_last = 1'b0;
  logic                 m_last;
  logic [NUM_LANES-1:0] m_keep;
`endif

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;
  int vcnt;

  frame_t             exp_q[$];
  logic [FRAME_W-1:0] mdl_frame = '0;
  int                 mdl_lane  = 0;

  adc_data_packer dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
`ifdef ADC_PACK_LAST_EN
    .s_last    (s_last),
    .m_last    (m_last),
    .m_keep    (m_keep),
`endif
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] mk_beat(input logic [7:0] tag);
    logic [LANE_W-1:0] b;
    for (int s = 0; s < SAMPLES_PER_LANE; s++) begin
      b[s*SAMPLE_W +: SAMPLE_W] = {10'(s + 1), tag};
    end
    return b;
  endfunction

  task automatic mdl_accept(input logic [LANE_W-1:0] d, input logic last);
    frame_t f;
    mdl_frame[mdl_lane*LANE_W +: LANE_W] = d;
    if (mdl_lane == NUM_LANES - 1 || (LAST_EN && last)) begin
      f.data = mdl_frame;
      f.keep = NUM_LANES'((1 << (mdl_lane + 1)) - 1);
      f.last = last;
      exp_q.push_back(f);
      mdl_frame = '0;
      mdl_lane  = 0;
    end else begin
      mdl_lane++;
    end
  endtask

  task automatic send_beat(input logic [LANE_W-1:0] d, input logic last);
    int waits = 0;
    @(negedge aclk);
    s_valid = 1'b1;
    s_data  = d;
`ifdef ADC_PACK_LAST_EN
    s_last  = last;
`endif
    #1;
    while (!s_ready && waits < 50) begin
      @(negedge aclk);
      #1;
      waits++;
    end
    if (waits > 0) stalls++;
    if (!s_ready) begin
      check_eq("beat_accept_timeout", s_ready, 1'b1);
    end else begin
      @(posedge aclk);
      mdl_accept(d, last);
    end
  endtask

  task automatic idle(input int n);
    @(negedge aclk);
    s_valid = 1'b0;
`ifdef ADC_PACK_LAST_EN
    s_last  = 1'b0;
`endif
    repeat (n) @(negedge aclk);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    mdl_frame = '0;
    mdl_lane  = 0;
    #1;
    check_eq("rst_s_ready", s_ready, 1'b0);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_frame_cnt", frame_cnt, 32'd0);
    check_eq("rst_m_data", m_data, '0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check_eq("rst_release_s_ready", s_ready, 1'b1);
  endtask

  // Scoreboard: a handoff happens at the next rising edge when valid and ready are both high now.
  initial begin
    frame_t e;
    forever begin
      @(negedge aclk);
      #3;
      if (aresetn && m_valid && m_ready) begin
        check_eq("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("frame_data", m_data, e.data);
`ifdef ADC_PACK_LAST_EN
          check_eq("frame_keep", m_keep, e.keep);
          check_eq("frame_last", m_last, e.last);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // single frame
    for (int i = 0; i < 4; i++) send_beat(mk_beat(8'(8'hA0 + i)), 1'b0);
    @(negedge aclk);
    s_valid = 1'b0;
    #1;
    check_eq("t1_latency_m_valid", m_valid, 1'b1);
    check_eq("t1_lane0", m_data[LANE_W-1:0], mk_beat(8'hA0));
    check_eq("t1_lane3", m_data[FRAME_W-1 -: LANE_W], mk_beat(8'hA3));
    vcnt = 0;
    repeat (4) begin
      if (m_valid) vcnt++;
      @(negedge aclk);
      #1;
    end
    check_eq("t1_valid_cycles", vcnt, 1);
    check_eq("t1_frame_cnt", frame_cnt, 32'd1);
    check_eq("t1_queue_empty", exp_q.size(), 0);

    // back-to-back at full rate
    do_reset();
    stalls = 0;
    for (int i = 0; i < 40; i++) send_beat(mk_beat(8'(i)), 1'b0);
    idle(3);
    check_eq("t2_no_stall", stalls, 0);
    check_eq("t2_frame_cnt", frame_cnt, 32'd10);
    check_eq("t2_queue_empty", exp_q.size(), 0);

    // sink backpressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(mk_beat(8'(8'hB0 + i)), 1'b0);
    stalls = 0;
    for (int i = 0; i < 3; i++) send_beat(mk_beat(8'(8'hC0 + i)), 1'b0);
    check_eq("t3_beats123_no_stall", stalls, 0);
    fork
      send_beat(mk_beat(8'hC3), 1'b0);
      begin
        repeat (3) @(negedge aclk);
        #1;
        check_eq("t3_stall_s_ready", s_ready, 1'b0);
        check_eq("t3_hold_m_valid", m_valid, 1'b1);
        check_eq("t3_hold_m_data", m_data, exp_q[0].data);
        @(negedge aclk);
        m_ready = 1'b1;
      end
    join
    @(negedge aclk);
    s_valid = 1'b0;
    #1;
    check_eq("t3_frame2_valid", m_valid, 1'b1);
    check_eq("t3_frame2_lane0", m_data[LANE_W-1:0], mk_beat(8'hC0));
    idle(3);
    check_eq("t3_frame_cnt", frame_cnt, 32'd2);
    check_eq("t3_queue_empty", exp_q.size(), 0);

    // reset mid-frame
    send_beat(mk_beat(8'hD0), 1'b0);
    send_beat(mk_beat(8'hD1), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(mk_beat(8'(8'hE0 + i)), 1'b0);
    idle(3);
    check_eq("t4_lane0_after_reset", m_data[LANE_W-1:0], mk_beat(8'hE0));
    check_eq("t4_frame_cnt", frame_cnt, 32'd1);
    check_eq("t4_queue_empty", exp_q.size(), 0);

    // frame counter wrap
    do_reset();
    force dut.u_outreg.r_frame_cnt = 32'hFFFF_FFFF;
    @(negedge aclk);
    release dut.u_outreg.r_frame_cnt;
    #1;
    check_eq("t5_preload", frame_cnt, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) send_beat(mk_beat(8'(8'h50 + i)), 1'b0);
    idle(3);
    check_eq("t5_wrap", frame_cnt, 32'd0);
    check_eq("t5_queue_empty", exp_q.size(), 0);

`ifdef ADC_PACK_LAST_EN
    // early emit on s_last
    do_reset();
    send_beat(mk_beat(8'hF0), 1'b0);
    send_beat(mk_beat(8'hF1), 1'b1);
    @(negedge aclk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    check_eq("t6_keep", m_keep, 4'b0011);
    check_eq("t6_last", m_last, 1'b1);
    check_eq("t6_upper_zero", m_data[FRAME_W-1:2*LANE_W], '0);
    for (int i = 0; i < 4; i++) send_beat(mk_beat(8'(8'h60 + i)), i == 3);
    @(negedge aclk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    check_eq("t6_full_keep", m_keep, 4'b1111);
    check_eq("t6_full_last", m_last, 1'b1);
    check_eq("t6_next_lane0", m_data[LANE_W-1:0], mk_beat(8'h60));
    idle(3);
    check_eq("t6_frame_cnt", frame_cnt, 32'd2);
    check_eq("t6_queue_empty", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
